// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types: FSM state encoding and the default boot vector.
package fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_next_pc_sel.sv
// Redirect priority mux (exception over branch) plus sequential pc+4.
module next_pc_sel (
    input  logic [31:0] pc,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] pc_inc
);

    assign redirect    = exc_valid || branch_valid;
    assign redirect_pc = exc_valid ? exc_target : branch_target;
    // Natural 32-bit wrap: 0xfffffffc + 4 -> 0
    assign pc_inc      = pc + 32'd4;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, a single
// output slot, and discard of responses made stale by a redirect.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d;
    logic         discard, discard_d;
    logic         out_valid_d;
    logic [31:0]  out_pc_d, out_inst_d;
    logic         redirect;
    logic [31:0]  redirect_pc, pc_inc;

    next_pc_sel u_next_pc_sel (
        .pc            (pc),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .exc_valid     (exc_valid),
        .exc_target    (exc_target),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .pc_inc        (pc_inc)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RESET;
            pc        <= RESET_PC;
            discard   <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= 32'd0;
            out_inst  <= 32'd0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            discard   <= discard_d;
            out_valid <= out_valid_d;
            out_pc    <= out_pc_d;
            out_inst  <= out_inst_d;
        end
    end

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        discard_d   = discard;
        out_valid_d = out_valid;
        out_pc_d    = out_pc;
        out_inst_d  = out_inst;
        imem_req    = 1'b0;

        if (out_valid && !stall)
            out_valid_d = 1'b0;

        case (state)
            S_RESET: begin
                state_d = S_REQ;
                if (redirect) begin
                    pc_d        = redirect_pc;
                    out_valid_d = 1'b0;
                end
            end
            S_REQ: begin
                // Only issue when the slot will be free to take the response
                imem_req = !out_valid || !stall;
                if (imem_req && imem_gnt)
                    state_d = S_WAIT;
                if (redirect) begin
                    pc_d        = redirect_pc;
                    out_valid_d = 1'b0;
                    if (imem_req && imem_gnt)
                        discard_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d        = redirect_pc;
                    out_valid_d = 1'b0;
                    if (imem_rvalid) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    state_d = S_REQ;
                    if (discard) begin
                        discard_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                        out_pc_d    = pc;
                        out_inst_d  = imem_rdata;
                        pc_d        = pc_inc;
                    end
                end
            end
            default: state_d = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl with a one-cycle-latency memory model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch_valid, exc_valid;
    logic [31:0] branch_target, exc_target;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        out_valid;
    logic [31:0] out_pc, out_inst;

    localparam logic [31:0] KEY = 32'h5a5a0000;

    logic        auto_mem;
    logic        rv_man;
    logic [31:0] rd_man;
    logic        pend;
    logic [31:0] paddr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .exc_valid     (exc_valid),
        .exc_target    (exc_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_inst      (out_inst)
    );

    // Memory: response one cycle after an accepted request, data = addr ^ KEY
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= 1'b0;
            paddr <= 32'd0;
        end else begin
            pend  <= imem_req && imem_gnt;
            paddr <= imem_addr;
        end
    end

    assign imem_rvalid = auto_mem ? pend : rv_man;
    assign imem_rdata  = auto_mem ? (paddr ^ KEY) : rd_man;

    typedef struct {
        logic        stall;
        logic        bv;
        logic [31:0] bt;
        logic        ev;
        logic [31:0] et;
        logic        req;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] opc;
        logic [31:0] inst;
    } vec_t;

    vec_t tv[25];

    function automatic vec_t mk(logic s, logic bv, logic [31:0] bt, logic ev, logic [31:0] et,
                                logic req, logic [31:0] addr, logic ov, logic [31:0] opc,
                                logic [31:0] inst);
        vec_t v;
        v.stall = s;  v.bv = bv;  v.bt = bt;  v.ev = ev;  v.et = et;
        v.req = req;  v.addr = addr;  v.ov = ov;  v.opc = opc;  v.inst = inst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0; branch_valid = 1'b0; exc_valid = 1'b0;
        branch_target = 32'd0; exc_target = 32'd0;
        imem_gnt = 1'b1; auto_mem = 1'b1; rv_man = 1'b0; rd_man = 32'd0;

        tv[0]  = mk(0,0,0,0,0, 0,32'hbfc00000, 0,32'h0,32'h0);
        tv[1]  = mk(0,0,0,0,0, 1,32'hbfc00000, 0,32'h0,32'h0);
        tv[2]  = mk(0,0,0,0,0, 0,32'hbfc00000, 0,32'h0,32'h0);
        tv[3]  = mk(0,0,0,0,0, 1,32'hbfc00004, 1,32'hbfc00000,32'hbfc00000^KEY);
        tv[4]  = mk(0,0,0,0,0, 0,32'hbfc00004, 0,32'hbfc00000,32'hbfc00000^KEY);
        for (int i = 5; i < 10; i++)
            tv[i] = mk(1,0,0,0,0, 0,32'hbfc00008, 1,32'hbfc00004,32'hbfc00004^KEY);
        tv[10] = mk(0,0,0,0,0, 1,32'hbfc00008, 1,32'hbfc00004,32'hbfc00004^KEY);
        tv[11] = mk(0,0,0,0,0, 0,32'hbfc00008, 0,32'hbfc00004,32'hbfc00004^KEY);
        tv[12] = mk(0,0,0,0,0, 1,32'hbfc0000c, 1,32'hbfc00008,32'hbfc00008^KEY);
        tv[13] = mk(0,1,32'h80001000,0,0, 0,32'hbfc0000c, 0,32'hbfc00008,32'hbfc00008^KEY);
        tv[14] = mk(0,0,0,0,0, 1,32'h80001000, 0,32'hbfc00008,32'hbfc00008^KEY);
        tv[15] = mk(0,1,32'h80000000,1,32'hbfc00380, 0,32'h80001000, 0,32'hbfc00008,32'hbfc00008^KEY);
        tv[16] = mk(0,0,0,0,0, 1,32'hbfc00380, 0,32'hbfc00008,32'hbfc00008^KEY);
        tv[17] = mk(0,0,0,0,0, 0,32'hbfc00380, 0,32'hbfc00008,32'hbfc00008^KEY);
        tv[18] = mk(0,0,0,1,32'hfffffffc, 1,32'hbfc00384, 1,32'hbfc00380,32'hbfc00380^KEY);
        tv[19] = mk(0,0,0,0,0, 0,32'hfffffffc, 0,32'hbfc00380,32'hbfc00380^KEY);
        tv[20] = mk(0,0,0,0,0, 1,32'hfffffffc, 0,32'hbfc00380,32'hbfc00380^KEY);
        tv[21] = mk(0,0,0,0,0, 0,32'hfffffffc, 0,32'hbfc00380,32'hbfc00380^KEY);
        tv[22] = mk(0,0,0,0,0, 1,32'h00000000, 1,32'hfffffffc,32'hfffffffc^KEY);
        tv[23] = mk(0,0,0,0,0, 0,32'h00000000, 0,32'hfffffffc,32'hfffffffc^KEY);
        tv[24] = mk(0,0,0,0,0, 1,32'h00000004, 1,32'h00000000,KEY);

        // Reset state
        cyc();
        chk("rst req",  {31'd0, imem_req},  32'd0);
        chk("rst addr", imem_addr,          32'hbfc00000);
        chk("rst ov",   {31'd0, out_valid}, 32'd0);
        chk("rst pc",   out_pc,             32'd0);
        chk("rst inst", out_inst,           32'd0);
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            stall = tv[i].stall;
            branch_valid = tv[i].bv; branch_target = tv[i].bt;
            exc_valid = tv[i].ev;    exc_target = tv[i].et;
            #1;
            chk($sformatf("row%0d req", i),  {31'd0, imem_req},  {31'd0, tv[i].req});
            chk($sformatf("row%0d addr", i), imem_addr,          tv[i].addr);
            chk($sformatf("row%0d ov", i),   {31'd0, out_valid}, {31'd0, tv[i].ov});
            chk($sformatf("row%0d opc", i),  out_pc,             tv[i].opc);
            chk($sformatf("row%0d inst", i), out_inst,           tv[i].inst);
            cyc();
        end
        stall = 1'b0; branch_valid = 1'b0; exc_valid = 1'b0;

        // Manual memory: stale response after redirect, stall-independent redirect, reset mid-wait
        auto_mem = 1'b0; imem_gnt = 1'b0;
        do_reset();
        branch_valid = 1'b1; branch_target = 32'h80003000;
        #1;
        chk("sreset req", {31'd0, imem_req}, 32'd0);
        cyc();
        branch_valid = 1'b0;
        chk("sreset redirect addr", imem_addr, 32'h80003000);
        chk("sreq req", {31'd0, imem_req}, 32'd1);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        branch_valid = 1'b1; branch_target = 32'h80001000;
        #1;
        chk("wait req", {31'd0, imem_req}, 32'd0);
        cyc();
        branch_valid = 1'b0;
        rv_man = 1'b1; rd_man = 32'hdeadbeef;
        #1;
        chk("discard wait req", {31'd0, imem_req}, 32'd0);
        cyc();
        rv_man = 1'b0;
        chk("stale ov", {31'd0, out_valid}, 32'd0);
        chk("stale inst", out_inst, 32'd0);
        chk("after discard req", {31'd0, imem_req}, 32'd1);
        chk("after discard addr", imem_addr, 32'h80001000);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        rv_man = 1'b1; rd_man = 32'h12345678;
        cyc();
        rv_man = 1'b0;
        chk("fill ov", {31'd0, out_valid}, 32'd1);
        chk("fill pc", out_pc, 32'h80001000);
        chk("fill inst", out_inst, 32'h12345678);
        chk("fill next addr", imem_addr, 32'h80001004);
        stall = 1'b1; branch_valid = 1'b1; branch_target = 32'h80002000;
        #1;
        chk("stalled req", {31'd0, imem_req}, 32'd0);
        cyc();
        branch_valid = 1'b0;
        chk("stall redirect ov", {31'd0, out_valid}, 32'd0);
        chk("stall redirect addr", imem_addr, 32'h80002000);
        chk("stall empty slot req", {31'd0, imem_req}, 32'd1);
        stall = 1'b0; imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("async rst req", {31'd0, imem_req}, 32'd0);
        chk("async rst addr", imem_addr, 32'hbfc00000);
        chk("async rst ov", {31'd0, out_valid}, 32'd0);
        chk("async rst pc", out_pc, 32'd0);
        chk("async rst inst", out_inst, 32'd0);
        rv_man = 1'b1; rd_man = 32'hcafef00d;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("post rst dead req", {31'd0, imem_req}, 32'd0);
        cyc();
        chk("post rst req", {31'd0, imem_req}, 32'd1);
        chk("post rst addr", imem_addr, 32'hbfc00000);
        chk("post rst ov", {31'd0, out_valid}, 32'd0);
        cyc();
        rv_man = 1'b0;
        chk("sreq rvalid ignored ov", {31'd0, out_valid}, 32'd0);
        chk("sreq rvalid ignored addr", imem_addr, 32'hbfc00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hbfc00000, meaning the first fetch address after reset.
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: stall  input  1  downstream not accepting the instruction slot.
REQ-005 SHALL have ports: branch_valid  input  1  branch redirect request; branch_target  input  32  redirect address.
REQ-006 SHALL have ports: exc_valid  input  1  exception/eret redirect request; exc_target  input  32  redirect address.
REQ-007 SHALL have ports: imem_req  output  1  fetch request; imem_addr  output  32  fetch address; imem_gnt  input  1  request accepted.
REQ-008 SHALL have ports: imem_rvalid  input  1  single-cycle response pulse; imem_rdata  input  32  instruction word.
REQ-009 SHALL have ports: out_valid  output  1  slot holds an instruction; out_pc  output  32  its address; out_inst  output  32  its word.

Function
REQ-010 SHALL hold internal register pc; imem_addr SHALL equal pc combinationally.
REQ-011 SHALL implement FSM states S_RESET, S_REQ, S_WAIT.
REQ-012 S_RESET: imem_req=0; next state S_REQ unconditionally (one dead cycle after reset release).
REQ-013 S_REQ: imem_req=1 only when (!out_valid || !stall); on imem_req && imem_gnt go S_WAIT, else stay.
REQ-014 S_WAIT: imem_req=0; at most one request outstanding at any time.
REQ-015 Slot consumed in any cycle with out_valid=1 && stall=0; consumption without refill clears out_valid next cycle.
REQ-016 S_WAIT with imem_rvalid, no discard, no redirect: next cycle out_valid=1, out_pc=pc, out_inst=imem_rdata; pc<=pc+4; state S_REQ.
REQ-017 pc+4 SHALL wrap modulo 2^32 (32'hfffffffc -> 32'h00000000); target alignment not checked, passed unmodified.
REQ-018 Redirect priority: exc_valid over branch_valid; redirects act regardless of stall.
REQ-019 On redirect: pc<=selected target; out_valid<=0 next cycle; state S_REQ unless outstanding.
REQ-020 Redirect while in S_WAIT, or in S_REQ with imem_req && imem_gnt same cycle: set discard flag, state S_WAIT.
REQ-021 imem_rvalid with discard set: response dropped, discard cleared, out_* unchanged, pc unchanged, state S_REQ.
REQ-022 Redirect in same cycle as imem_rvalid: response dropped, no discard set, pc<=target, state S_REQ.
REQ-023 imem_rvalid in S_RESET or S_REQ SHALL be ignored.
REQ-024 Redirect in S_RESET: pc updated; S_REQ entered as normal.

Reset
REQ-025 On rst=1, immediately: state S_RESET, pc=RESET_PC, discard=0, out_valid=0, out_pc=0, out_inst=0, imem_req=0, imem_addr=RESET_PC.
REQ-026 Reset mid-transaction SHALL abandon the outstanding request; no response accepted until a new request is granted.

Structure
REQ-027 State enum typedef and RESET_PC default SHALL live in the shared CPU package/header.
REQ-028 One sub-module next_pc_sel (combinational redirect priority mux plus pc+4) is natural; FSM, slot and discard stay in fetch_ctrl.

Verification
REQ-029 Reset release, gnt tied 1, rvalid one cycle after gnt, stall=0 -> imem_addr 0xbfc00000, 0xbfc00004, 0xbfc00008; out_pc follows in order.
REQ-030 stall=1 for 5 cycles with out_valid=1 -> imem_req=0, out_pc/out_inst held; fetch resumes the cycle stall drops.
REQ-031 branch_valid target 0x80001000 while S_WAIT -> stale rvalid dropped; next imem_addr 0x80001000; no stale out_valid.
REQ-032 exc_valid (0xbfc00380) and branch_valid (0x80000000) same cycle -> next imem_addr 0xbfc00380.
REQ-033 pc=0xfffffffc fetched -> next imem_addr 0x00000000.
REQ-034 rst asserted while S_WAIT -> outputs per REQ-025 same cycle; first request 0xbfc00000 two cycles after release.
